// File: rtl/packet_checker.sv
// packet_checker: receive-side checker for the loopback performance test.
// Consumes returning AXI-Stream frames and checks the payload pattern on kept
// bytes, the keep encoding and the total frame length. It counts good and bad
// frames and pulses o_rx_last_received once per completed frame.
// Optional feature macro: PACKET_CHECKER_LATENCY_EN builds the round-trip
// latency counter and the o_last_latency / o_max_latency outputs. Without it,
// both latency outputs are tied to zero.

module packet_checker #(
    parameter logic [31:0] EXPECTED_DATA = 32'hFFFFAAAA,
    parameter int          LAT_W         = 16
) (
    input  logic             s_axis_clk,
    input  logic             i_reset_n,
    input  logic             s_axis_tvalid,
    output logic             s_axis_tready,
    input  logic [31:0]      s_axis_tdata,
    input  logic [3:0]       s_axis_tkeep,
    input  logic             s_axis_tlast,
    input  logic             s_axis_tuser,
    input  logic [9:0]       i_vio_packet_bytes,
    input  logic             i_sync_first_byte_sent,
    output logic             o_rx_last_received,
    output logic [31:0]      o_frame_count,
    output logic [15:0]      o_error_count,
    output logic [LAT_W-1:0] o_last_latency,
    output logic [LAT_W-1:0] o_max_latency
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;

    logic        tready_q;
    logic [9:0]  q_exp_bytes;
    logic [10:0] q_rx_bytes;

    logic        accept;
    logic        frame_done;
    logic        data_bad;
    logic        keep_bad;
    logic        beat_bad;
    logic        frame_bad;
    logic [2:0]  keep_count;
    logic [11:0] byte_sum;
    logic [10:0] byte_total;

    assign s_axis_tready = tready_q;
    assign accept        = s_axis_tvalid & tready_q;
    assign frame_done    = accept & s_axis_tlast;

    // Per-beat checks: pattern on kept bytes, keep encoding, and byte totals.
    always_comb begin
        data_bad = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (s_axis_tkeep[i] && (s_axis_tdata[8*i +: 8] != EXPECTED_DATA[8*i +: 8])) begin
                data_bad = 1'b1;
            end
        end

        keep_bad = 1'b0;
        if (s_axis_tlast) begin
            case (s_axis_tkeep)
                4'b0001, 4'b0011, 4'b0111, 4'b1111: keep_bad = 1'b0;
                default:                            keep_bad = 1'b1;
            endcase
        end else begin
            keep_bad = (s_axis_tkeep != 4'b1111);
        end

        beat_bad   = data_bad | keep_bad;
        keep_count = {2'b00, s_axis_tkeep[0]} + {2'b00, s_axis_tkeep[1]}
                   + {2'b00, s_axis_tkeep[2]} + {2'b00, s_axis_tkeep[3]};
        byte_sum   = {1'b0, q_rx_bytes} + {9'd0, keep_count};
        byte_total = byte_sum[11] ? 11'h7FF : byte_sum[10:0];
        frame_bad  = (state == DRAIN) | beat_bad | s_axis_tuser
                   | (byte_total != {1'b0, q_exp_bytes});
    end

    // Next-state logic; a failing first beat goes straight to DRAIN so the
    // frame stays marked bad until its tlast arrives.
    always_comb begin
        state_next = state;
        if (accept) begin
            case (state)
                IDLE, RECV: begin
                    if (s_axis_tlast) begin
                        state_next = IDLE;
                    end else if (beat_bad) begin
                        state_next = DRAIN;
                    end else begin
                        state_next = RECV;
                    end
                end
                DRAIN: begin
                    if (s_axis_tlast) begin
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // State register and the always-ready handshake (low only in reset).
    always_ff @(posedge s_axis_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state    <= IDLE;
            tready_q <= 1'b0;
        end else begin
            state    <= state_next;
            tready_q <= 1'b1;
        end
    end

    // Expected frame length, captured from the generator's start pulse.
    always_ff @(posedge s_axis_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            q_exp_bytes <= 10'd0;
        end else if (i_sync_first_byte_sent) begin
            q_exp_bytes <= i_vio_packet_bytes;
        end
    end

    // Running byte count of the current frame, cleared when the frame completes.
    always_ff @(posedge s_axis_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            q_rx_bytes <= 11'd0;
        end else if (frame_done) begin
            q_rx_bytes <= 11'd0;
        end else if (accept) begin
            q_rx_bytes <= byte_total;
        end
    end

    // Frame/error counters and the completion pulse, all one clock after tlast.
    always_ff @(posedge s_axis_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_rx_last_received <= 1'b0;
            o_frame_count      <= 32'd0;
            o_error_count      <= 16'd0;
        end else begin
            o_rx_last_received <= frame_done;
            if (frame_done) begin
                o_frame_count <= o_frame_count + 32'd1;
                if (frame_bad && (o_error_count != 16'hFFFF)) begin
                    o_error_count <= o_error_count + 16'd1;
                end
            end
        end
    end

`ifdef PACKET_CHECKER_LATENCY_EN
    localparam logic [LAT_W-1:0] LAT_MAX = '1;
    localparam logic [LAT_W-1:0] LAT_ONE = {{(LAT_W-1){1'b0}}, 1'b1};

    logic [LAT_W-1:0] q_lat;
    logic             q_lat_run;
    logic [LAT_W-1:0] lat_stop;

    // The tlast edge itself counts as one more clock, so the captured value is
    // the counter plus one; this makes start at N and tlast at N+k report k.
    assign lat_stop = (q_lat == LAT_MAX) ? LAT_MAX : (q_lat + LAT_ONE);

    // Latency counter: restarts on every start pulse, stops on tlast.
    always_ff @(posedge s_axis_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            q_lat     <= '0;
            q_lat_run <= 1'b0;
        end else if (i_sync_first_byte_sent) begin
            q_lat     <= '0;
            q_lat_run <= 1'b1;
        end else if (frame_done) begin
            q_lat_run <= 1'b0;
        end else if (q_lat_run && (q_lat != LAT_MAX)) begin
            q_lat <= q_lat + LAT_ONE;
        end
    end

    // Latency capture on a completing frame that had a running counter.
    always_ff @(posedge s_axis_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_last_latency <= '0;
            o_max_latency  <= '0;
        end else if (frame_done && q_lat_run) begin
            o_last_latency <= lat_stop;
            if (lat_stop > o_max_latency) begin
                o_max_latency <= lat_stop;
            end
        end
    end
`else
    assign o_last_latency = '0;
    assign o_max_latency  = '0;
`endif

endmodule

// File: tb/tb_packet_checker.sv
// tb_packet_checker: self-checking bench for packet_checker.
// Frames are built as beat arrays. A behavioural model judges each frame
// directly from the frame rules: kept bytes match, full keep mid-frame,
// contiguous keep on the last beat, tuser clear, and byte total equal to the
// configured length. Latency is the model's cycle distance from start pulse
// to tlast. Latency expectations collapse to zero when
// PACKET_CHECKER_LATENCY_EN is undefined.

module tb_packet_checker;

    localparam logic [31:0] EXP_WORD = 32'hFFFFAAAA;
`ifdef PACKET_CHECKER_LATENCY_EN
    localparam bit LAT_EN = 1'b1;
`else
    localparam bit LAT_EN = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        tvalid;
    logic        tready;
    logic [31:0] tdata;
    logic [3:0]  tkeep;
    logic        tlast;
    logic        tuser;
    logic [9:0]  pkt_bytes;
    logic        sync;
    logic        pulse;
    logic [31:0] frame_count;
    logic [15:0] error_count;
    logic [15:0] last_lat;
    logic [15:0] max_lat;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;

    logic [31:0] bd [64];
    logic [3:0]  bk [64];

    logic [9:0]  m_exp_bytes;
    logic [31:0] m_frames;
    logic [15:0] m_errors;
    int          m_last_lat;
    int          m_max_lat;
    int          m_start;
    bit          m_running;

    packet_checker dut (
        .s_axis_clk             (clk),
        .i_reset_n              (rst_n),
        .s_axis_tvalid          (tvalid),
        .s_axis_tready          (tready),
        .s_axis_tdata           (tdata),
        .s_axis_tkeep           (tkeep),
        .s_axis_tlast           (tlast),
        .s_axis_tuser           (tuser),
        .i_vio_packet_bytes     (pkt_bytes),
        .i_sync_first_byte_sent (sync),
        .o_rx_last_received     (pulse),
        .o_frame_count          (frame_count),
        .o_error_count          (error_count),
        .o_last_latency         (last_lat),
        .o_max_latency          (max_lat)
    );

    // Free-running clock, 10 time-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case something stalls the sequence.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached before summary");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [15:0] lat_view(input int v);
        return LAT_EN ? 16'(v) : 16'd0;
    endfunction

    // Frame verdict computed straight from the frame rules.
    function automatic bit model_bad(input int n, input bit user, input logic [9:0] expb);
        int          bytes = 0;
        bit          bad   = 1'b0;
        logic [31:0] w     = EXP_WORD;
        for (int i = 0; i < n; i++) begin
            for (int b = 0; b < 4; b++) begin
                if (bk[i][b] && (bd[i][8*b +: 8] != w[8*b +: 8])) bad = 1'b1;
            end
            if ((i != n - 1) && (bk[i] != 4'hF)) bad = 1'b1;
            bytes += $countones(bk[i]);
        end
        if (!(bk[n-1] inside {4'b0001, 4'b0011, 4'b0111, 4'b1111})) bad = 1'b1;
        if (user) bad = 1'b1;
        if (bytes > 2047) bytes = 2047;
        if (bytes != int'(expb)) bad = 1'b1;
        return bad;
    endfunction

    task automatic model_reset();
        m_exp_bytes = 10'd0;
        m_frames    = 32'd0;
        m_errors    = 16'd0;
        m_last_lat  = 0;
        m_max_lat   = 0;
        m_start     = 0;
        m_running   = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic idle(input int k);
        repeat (k) tick();
    endtask

    task automatic pulse_start(input logic [9:0] b);
        sync      = 1'b1;
        pkt_bytes = b;
        tick();
        sync        = 1'b0;
        m_exp_bytes = b;
        m_start     = cyc;
        m_running   = 1'b1;
    endtask

    task automatic fill_good(input int n);
        for (int i = 0; i < n; i++) begin
            bd[i] = EXP_WORD;
            bk[i] = 4'hF;
        end
    endtask

    task automatic drive_beat(input logic [31:0] d, input logic [3:0] k,
                              input logic l, input logic u);
        tvalid = 1'b1;
        tdata  = d;
        tkeep  = k;
        tlast  = l;
        tuser  = u;
        tick();
        tvalid = 1'b0;
        tlast  = 1'b0;
        tuser  = 1'b0;
    endtask

    // Drives the beat arrays as one frame and advances the model at the tlast edge.
    task automatic drive_frame(input int n, input bit user, input bit sync_last,
                               input logic [9:0] sync_bytes);
        bit bad;
        int lat;
        bad = model_bad(n, user, m_exp_bytes);
        for (int i = 0; i < n; i++) begin
            tvalid = 1'b1;
            tdata  = bd[i];
            tkeep  = bk[i];
            tlast  = (i == n - 1);
            tuser  = (i == n - 1) ? user : 1'($urandom);
            if ((i == n - 1) && sync_last) begin
                sync      = 1'b1;
                pkt_bytes = sync_bytes;
            end
            tick();
        end
        tvalid = 1'b0;
        tlast  = 1'b0;
        tuser  = 1'b0;
        sync   = 1'b0;
        m_frames = m_frames + 32'd1;
        if (bad && (m_errors != 16'hFFFF)) m_errors = m_errors + 16'd1;
        if (m_running) begin
            lat = cyc - m_start;
            if (lat > 65535) lat = 65535;
            m_last_lat = lat;
            if (lat > m_max_lat) m_max_lat = lat;
            m_running = 1'b0;
        end
        if (sync_last) begin
            m_exp_bytes = sync_bytes;
            m_start     = cyc;
            m_running   = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        tvalid    = 1'b0;
        tdata     = 32'd0;
        tkeep     = 4'd0;
        tlast     = 1'b0;
        tuser     = 1'b0;
        sync      = 1'b0;
        pkt_bytes = 10'd0;
        model_reset();
        idle(3);
        compared++;
        if (tready !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_tready: got %b expected 0", tready);
        end
        compared++;
        if ((frame_count !== 32'd0) || (error_count !== 16'd0) || (pulse !== 1'b0)) begin
            mismatched++;
            $display("[TB] FAIL reset_counts: frames %0d errors %0d pulse %b expected 0/0/0",
                     frame_count, error_count, pulse);
        end
        compared++;
        if ((last_lat !== 16'd0) || (max_lat !== 16'd0)) begin
            mismatched++;
            $display("[TB] FAIL reset_latency: last %0d max %0d expected 0/0", last_lat, max_lat);
        end
        rst_n = 1'b1;
        tick();
        compared++;
        if (tready !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL release_tready: got %b expected 1", tready);
        end
    endtask

    task automatic test_good_frame();
        pulse_start(10'd64);
        idle(2);
        fill_good(16);
        drive_frame(16, 1'b0, 1'b0, 10'd0);
        compared++;
        if (pulse !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL good_pulse: got %b expected 1", pulse);
        end
        compared++;
        if ((frame_count !== m_frames) || (error_count !== m_errors)) begin
            mismatched++;
            $display("[TB] FAIL good_counts: frames %0d errors %0d expected %0d/%0d",
                     frame_count, error_count, m_frames, m_errors);
        end
        compared++;
        if (last_lat !== lat_view(m_last_lat)) begin
            mismatched++;
            $display("[TB] FAIL good_latency: got %0d expected %0d", last_lat, lat_view(m_last_lat));
        end
        idle(1);
        compared++;
        if (pulse !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL good_pulse_width: got %b expected 0", pulse);
        end
    endtask

    task automatic test_length();
        logic [3:0] last_keeps [2] = '{4'b0001, 4'b0011};
        for (int t = 0; t < 2; t++) begin
            pulse_start(10'd61);
            idle(1);
            fill_good(16);
            bk[15] = last_keeps[t];
            drive_frame(16, 1'b0, 1'b0, 10'd0);
            compared++;
            if ((pulse !== 1'b1) || (error_count !== m_errors) || (frame_count !== m_frames)) begin
                mismatched++;
                $display("[TB] FAIL length_keep%0b: pulse %b errors %0d frames %0d expected 1/%0d/%0d",
                         last_keeps[t], pulse, error_count, frame_count, m_errors, m_frames);
            end
        end
    endtask

    task automatic test_pattern();
        pulse_start(10'd64);
        idle(1);
        fill_good(16);
        bd[3] = 32'hFFFFAABA;
        drive_frame(16, 1'b0, 1'b0, 10'd0);
        compared++;
        if (error_count !== m_errors) begin
            mismatched++;
            $display("[TB] FAIL pattern_error: got %0d expected %0d", error_count, m_errors);
        end
        pulse_start(10'd62);
        idle(1);
        fill_good(16);
        bk[15] = 4'b0011;
        bd[15] = {EXP_WORD[31:16] ^ 16'($urandom_range(1, 65535)), EXP_WORD[15:0]};
        drive_frame(16, 1'b0, 1'b0, 10'd0);
        compared++;
        if (error_count !== m_errors) begin
            mismatched++;
            $display("[TB] FAIL pattern_masked: got %0d expected %0d", error_count, m_errors);
        end
    endtask

    task automatic test_user_keep();
        pulse_start(10'd64);
        idle(1);
        fill_good(16);
        drive_frame(16, 1'b1, 1'b0, 10'd0);
        compared++;
        if (error_count !== m_errors) begin
            mismatched++;
            $display("[TB] FAIL tuser_error: got %0d expected %0d", error_count, m_errors);
        end
        pulse_start(10'd63);
        idle(1);
        fill_good(16);
        bk[5] = 4'b0111;
        drive_frame(16, 1'b0, 1'b0, 10'd0);
        compared++;
        if (error_count !== m_errors) begin
            mismatched++;
            $display("[TB] FAIL mid_keep_error: got %0d expected %0d", error_count, m_errors);
        end
        pulse_start(10'd62);
        idle(1);
        fill_good(16);
        bk[15] = 4'b0101;
        drive_frame(16, 1'b0, 1'b0, 10'd0);
        compared++;
        if ((error_count !== m_errors) || (frame_count !== m_frames)) begin
            mismatched++;
            $display("[TB] FAIL last_keep_error: errors %0d frames %0d expected %0d/%0d",
                     error_count, frame_count, m_errors, m_frames);
        end
    endtask

    task automatic test_latency();
        int gaps [2] = '{21, 4};
        for (int t = 0; t < 2; t++) begin
            pulse_start(10'd64);
            idle(gaps[t]);
            fill_good(16);
            drive_frame(16, 1'b0, 1'b0, 10'd0);
            compared++;
            if ((last_lat !== lat_view(m_last_lat)) || (max_lat !== lat_view(m_max_lat))) begin
                mismatched++;
                $display("[TB] FAIL latency_run%0d: last %0d max %0d expected %0d/%0d", t,
                         last_lat, max_lat, lat_view(m_last_lat), lat_view(m_max_lat));
            end
        end
        pulse_start(10'd64);
        idle(1);
        fill_good(16);
        drive_frame(16, 1'b0, 1'b1, 10'd64);
        compared++;
        if (last_lat !== lat_view(m_last_lat)) begin
            mismatched++;
            $display("[TB] FAIL latency_coincident_capture: got %0d expected %0d",
                     last_lat, lat_view(m_last_lat));
        end
        idle(9);
        drive_frame(16, 1'b0, 1'b0, 10'd0);
        compared++;
        if ((last_lat !== lat_view(m_last_lat)) || (error_count !== m_errors)) begin
            mismatched++;
            $display("[TB] FAIL latency_restart: last %0d errors %0d expected %0d/%0d",
                     last_lat, error_count, lat_view(m_last_lat), m_errors);
        end
        idle(3);
        drive_frame(16, 1'b0, 1'b0, 10'd0);
        compared++;
        if ((last_lat !== lat_view(m_last_lat)) || (max_lat !== lat_view(m_max_lat))) begin
            mismatched++;
            $display("[TB] FAIL latency_not_running: last %0d max %0d expected %0d/%0d",
                     last_lat, max_lat, lat_view(m_last_lat), lat_view(m_max_lat));
        end
    endtask

    task automatic test_back_to_back();
        pulse_start(10'd64);
        fill_good(16);
        drive_frame(16, 1'b0, 1'b0, 10'd0);
        compared++;
        if (pulse !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL b2b_first_pulse: got %b expected 1", pulse);
        end
        drive_frame(16, 1'b0, 1'b0, 10'd0);
        compared++;
        if ((pulse !== 1'b1) || (frame_count !== m_frames) || (error_count !== m_errors)) begin
            mismatched++;
            $display("[TB] FAIL b2b_second: pulse %b frames %0d errors %0d expected 1/%0d/%0d",
                     pulse, frame_count, error_count, m_frames, m_errors);
        end
    endtask

    task automatic test_random();
        int  n;
        int  bytes;
        bit  user;
        bit  sync_last;
        for (int f = 0; f < 40; f++) begin
            n = $urandom_range(1, 8);
            fill_good(n);
            bytes = 0;
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 9) == 0) bd[i] = bd[i] ^ (32'd1 << $urandom_range(0, 31));
                if ((i < n - 1) && ($urandom_range(0, 9) == 0)) bk[i] = 4'($urandom);
            end
            case ($urandom_range(0, 5))
                0:       bk[n-1] = 4'($urandom);
                1:       bk[n-1] = 4'b0001;
                2:       bk[n-1] = 4'b0011;
                3:       bk[n-1] = 4'b0111;
                default: bk[n-1] = 4'b1111;
            endcase
            for (int i = 0; i < n; i++) bytes += $countones(bk[i]);
            user      = ($urandom_range(0, 9) == 0);
            sync_last = ($urandom_range(0, 6) == 0);
            if ($urandom_range(0, 4) != 0) begin
                pulse_start(($urandom_range(0, 3) != 0) ? 10'(bytes) : 10'($urandom));
            end
            idle($urandom_range(0, 3));
            drive_frame(n, user, sync_last, 10'(bytes));
            compared++;
            if ((pulse !== 1'b1) || (frame_count !== m_frames) || (error_count !== m_errors)) begin
                mismatched++;
                $display("[TB] FAIL random_frame%0d: pulse %b frames %0d errors %0d expected 1/%0d/%0d",
                         f, pulse, frame_count, error_count, m_frames, m_errors);
            end
            compared++;
            if ((last_lat !== lat_view(m_last_lat)) || (max_lat !== lat_view(m_max_lat))) begin
                mismatched++;
                $display("[TB] FAIL random_latency%0d: last %0d max %0d expected %0d/%0d", f,
                         last_lat, max_lat, lat_view(m_last_lat), lat_view(m_max_lat));
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        pulse_start(10'd64);
        for (int i = 0; i < 5; i++) drive_beat(EXP_WORD, 4'hF, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        compared++;
        if ((frame_count !== 32'd0) || (error_count !== 16'd0) || (pulse !== 1'b0) ||
            (tready !== 1'b0) || (last_lat !== 16'd0) || (max_lat !== 16'd0)) begin
            mismatched++;
            $display("[TB] FAIL async_reset: frames %0d errors %0d pulse %b tready %b last %0d max %0d expected all 0",
                     frame_count, error_count, pulse, tready, last_lat, max_lat);
        end
        idle(2);
        rst_n = 1'b1;
        model_reset();
        tick();
        pulse_start(10'd64);
        idle(2);
        fill_good(16);
        drive_frame(16, 1'b0, 1'b0, 10'd0);
        compared++;
        if ((frame_count !== m_frames) || (error_count !== m_errors) ||
            (last_lat !== lat_view(m_last_lat))) begin
            mismatched++;
            $display("[TB] FAIL after_reset_frame: frames %0d errors %0d last %0d expected %0d/%0d/%0d",
                     frame_count, error_count, last_lat, m_frames, m_errors, lat_view(m_last_lat));
        end
    endtask

    // Runs every scenario in order, then prints the one summary line.
    initial begin
        test_reset();
        test_good_frame();
        test_length();
        test_pattern();
        test_user_keep();
        test_latency();
        test_back_to_back();
        test_random();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
